// File: rtl/pb_ir_emulator.sv
// Push-button / PIR stimulus generator: bouncy or clean presses, IR pulses and IR levels.
// Optional abort input is enabled by defining PB_IR_EMU_ABORT_EN.
module pb_ir_emulator #(
   parameter int unsigned BOUNCE_T    = 40,
   parameter int unsigned CNT_W       = 16,
   parameter logic [7:0]  BOUNCE_SEED = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_len,
   output logic             push_button,
   output logic             infravermelho,
   output logic             busy,
   output logic             done
`ifdef PB_IR_EMU_ABORT_EN
   ,
   input  logic             abort
`endif
);

   typedef enum logic [2:0] {StIdle, StBPress, StHold, StBRel, StIrOn, StDone} state_e;

   localparam logic [1:0]       OpPress   = 2'b00;
   localparam logic [1:0]       OpClean   = 2'b01;
   localparam logic [1:0]       OpPulse   = 2'b10;
   localparam logic [7:0]       SeedEff   = (BOUNCE_SEED == 8'h00) ? 8'h01 : BOUNCE_SEED;
   localparam logic [CNT_W-1:0] BounceM1  = CNT_W'(BOUNCE_T - 1);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             press_q, press_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic             pb_q, pb_d;
   logic             ir_q, ir_d;
   logic             ir_lvl_q, ir_lvl_d;
   logic [CNT_W-1:0] len_m1;

   // A zero length behaves like a length of one.
   assign len_m1 = (cmd_len == '0) ? '0 : cmd_len - CntOne;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      press_d  = press_q;
      lfsr_d   = lfsr_q;
      pb_d     = pb_q;
      ir_d     = ir_q;
      ir_lvl_d = ir_lvl_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               len_d   = len_m1;
               press_d = (cmd_op == OpPress);
               case (cmd_op)
                  OpPress: begin
                     state_d = StBPress;
                     cnt_d   = BounceM1;
                     pb_d    = lfsr_q[0];
                  end
                  OpClean: begin
                     state_d = StHold;
                     cnt_d   = len_m1;
                     pb_d    = 1'b1;
                  end
                  OpPulse: begin
                     state_d = StIrOn;
                     cnt_d   = len_m1;
                     ir_d    = 1'b1;
                  end
                  default: begin
                     state_d  = StDone;
                     ir_lvl_d = cmd_len[0];
                     ir_d     = cmd_len[0];
                  end
               endcase
            end
         end
         StBPress: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               cnt_d   = len_q;
               pb_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - CntOne;
               pb_d  = (cnt_q == CntOne) ? 1'b1 : lfsr_q[0];
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               if (press_q) begin
                  state_d = StBRel;
                  cnt_d   = BounceM1;
                  pb_d    = lfsr_q[0];
               end else begin
                  state_d = StDone;
                  pb_d    = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StBRel: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               pb_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - CntOne;
               pb_d  = (cnt_q == CntOne) ? 1'b0 : lfsr_q[0];
            end
         end
         StIrOn: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               ir_d    = ir_lvl_q;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // One LFSR step per emitted bounce value.
      if (state_d == StBPress || state_d == StBRel) begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end

`ifdef PB_IR_EMU_ABORT_EN
      if (abort) begin
         state_d  = StIdle;
         cnt_d    = cnt_q;
         len_d    = len_q;
         press_d  = press_q;
         lfsr_d   = lfsr_q;
         pb_d     = 1'b0;
         ir_d     = ir_lvl_q;
         ir_lvl_d = ir_lvl_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         len_q    <= '0;
         press_q  <= 1'b0;
         lfsr_q   <= SeedEff;
         pb_q     <= 1'b0;
         ir_q     <= 1'b0;
         ir_lvl_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         press_q  <= press_d;
         lfsr_q   <= lfsr_d;
         pb_q     <= pb_d;
         ir_q     <= ir_d;
         ir_lvl_q <= ir_lvl_d;
      end
   end

   assign cmd_ready     = (state_q == StIdle);
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign push_button   = pb_q;
   assign infravermelho = ir_q;

endmodule

// File: tb/tb_pb_ir_emulator.sv
// Directed bench for pb_ir_emulator (BOUNCE_T=4, seed 8'hA5); samples on the falling edge.
module tb_pb_ir_emulator;

   localparam int unsigned CNT_W = 16;
   // push_button after E0+k for PRESS L=8: bounce 1,0,1,(1) / 8 ones / bounce 0,1,1,(0) / done 0
   localparam logic [16:0] PressPb = 17'b0_0110_1111_1111_1101;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [CNT_W-1:0] cmd_len = '0;
   logic             push_button;
   logic             infravermelho;
   logic             busy;
   logic             done;
   logic             abort = 1'b0;

   int checks = 0;
   int errors = 0;

   pb_ir_emulator #(
      .BOUNCE_T   (4),
      .CNT_W      (CNT_W),
      .BOUNCE_SEED(8'hA5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_len      (cmd_len),
      .push_button  (push_button),
      .infravermelho(infravermelho),
      .busy         (busy),
      .done         (done)
`ifdef PB_IR_EMU_ABORT_EN
      ,
      .abort        (abort)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer one command for a single accept edge; returns just after that edge (E0).
   task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] len);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_pb", 32'(push_button), 32'd0);
      chk("rst_ir", 32'(infravermelho), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // PRESS_CLEAN L=5
      issue(2'b01, 16'd5);
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k < 5) begin
            chk("clean_pb_hi", 32'(push_button), 32'd1);
            chk("clean_busy", 32'(busy), 32'd1);
         end else if (k == 5) begin
            chk("clean_pb_lo", 32'(push_button), 32'd0);
            chk("clean_done", 32'(done), 32'd1);
            chk("clean_notready", 32'(cmd_ready), 32'd0);
         end else begin
            chk("clean_ready", 32'(cmd_ready), 32'd1);
            chk("clean_done_lo", 32'(done), 32'd0);
         end
      end

      // PRESS bouncy L=8, LFSR still at seed
      issue(2'b00, 16'd8);
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         if (k <= 16) begin
            chk($sformatf("press_pb_%0d", k), 32'(push_button), 32'(PressPb[k]));
            chk($sformatf("press_done_%0d", k), 32'(done), 32'(k == 16));
         end else begin
            chk("press_ready", 32'(cmd_ready), 32'd1);
         end
      end

      // Reset while holding a PRESS L=10
      issue(2'b00, 16'd10);
      repeat (7) @(negedge clk);
      chk("hold_pb", 32'(push_button), 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_pb", 32'(push_button), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_ir", 32'(infravermelho), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("arst_ready", 32'(cmd_ready), 32'd1);
         chk("arst_nodone", 32'(done), 32'd0);
      end

      // IR_LEVEL 1, IR_PULSE L=3, IR_LEVEL 0
      issue(2'b11, 16'd1);
      @(negedge clk);
      chk("lvl1_ir", 32'(infravermelho), 32'd1);
      chk("lvl1_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("lvl1_ready", 32'(cmd_ready), 32'd1);
      issue(2'b10, 16'd3);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("pulse_ir", 32'(infravermelho), 32'd1);
         chk("pulse_done", 32'(done), 32'(k == 3));
      end
      issue(2'b11, 16'd0);
      @(negedge clk);
      chk("lvl0_ir", 32'(infravermelho), 32'd0);
      chk("lvl0_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("lvl0_ir_hold", 32'(infravermelho), 32'd0);

      // Back-to-back PRESS_CLEAN with cmd_valid held; second has cmd_len=0
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_len   = 16'd1;
      @(posedge clk);
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         cmd_len = '0;
         chk($sformatf("b2b_pb_%0d", k), 32'(push_button), 32'(k == 0 || k == 3));
         chk($sformatf("b2b_done_%0d", k), 32'(done), 32'(k == 1 || k == 4));
         chk($sformatf("b2b_ready_%0d", k), 32'(cmd_ready), 32'(k == 2 || k == 5));
         if (k == 4) cmd_valid = 1'b0;
      end

`ifdef PB_IR_EMU_ABORT_EN
      // Abort in HOLD cycle 20 of PRESS L=100
      issue(2'b00, 16'd100);
      repeat (24) @(negedge clk);
      chk("abt_pre_pb", 32'(push_button), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abt_pb", 32'(push_button), 32'd0);
      chk("abt_busy", 32'(busy), 32'd0);
      chk("abt_ir", 32'(infravermelho), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abt_nodone", 32'(done), 32'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
